// File: rtl/spi_frame_rx_pkg.sv
// Shared definitions for the SPI register write path: FSM states, frame field
// positions and the register map used by the downstream PWM register bank.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int unsigned RW_BIT   = 15;
  localparam int unsigned ADDR_MSB = 14;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;

  localparam logic [6:0] DEF_MAX_ADDR = 7'h04;

  localparam logic [6:0] REG_ENABLE  = 7'h00;
  localparam logic [6:0] REG_DUTY0   = 7'h01;
  localparam logic [6:0] REG_DUTY1   = 7'h02;
  localparam logic [6:0] REG_DUTY2   = 7'h03;
  localparam logic [6:0] REG_DUTY3   = 7'h04;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Write-strobe bus from the SPI frame receiver to the register bank.
interface spi_frame_rx_if;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  modport master (output wr_valid, wr_addr, wr_data, frame_err, busy);
  modport slave  (input  wr_valid, wr_addr, wr_data, frame_err, busy);
endinterface

// File: rtl/spi_frame_rx_sync_edge.sv
// N-stage input synchronizer with a history flop and registered one-cycle
// rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              r_rise;
  logic              r_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_hist;
      r_fall <= ~r_sync[STAGES-1] & r_hist;
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronizes the pins, assembles 16-bit write
// frames and issues a one-cycle write or error strobe on chip-select release.
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = DEF_MAX_ADDR,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sclk,
  input  logic           ncs,
  input  logic           sdi,
  spi_frame_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);

  logic                   w_unused_sclk_sync;
  logic                   w_sclk_rise;
  logic                   w_unused_sclk_fall;
  logic                   w_ncs_sync;
  logic                   w_ncs_rise;
  logic                   w_ncs_fall;
  logic                   w_sdi;
  logic                   w_accept;

  logic [SYNC_STAGES-1:0] r_sdi_sync;
  state_t                 r_state,    w_state_next;
  logic [CNT_W-1:0]       r_cnt,      w_cnt_next;
  logic [FRAME_BITS-1:0]  r_shift,    w_shift_next;
  logic                   r_wr_valid, w_wr_valid_next;
  logic                   r_err,      w_err_next;
  logic [6:0]             r_addr,     w_addr_next;
  logic [7:0]             r_data,     w_data_next;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (sclk),
    .o_sync  (w_unused_sclk_sync),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_unused_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (ncs),
    .o_sync  (w_ncs_sync),
    .o_rise  (w_ncs_rise),
    .o_fall  (w_ncs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sdi_sync <= '0;
    else        r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
  end

  assign w_sdi    = r_sdi_sync[SYNC_STAGES-1];
  assign w_accept = (r_cnt == CNT_W'(FRAME_BITS)) && r_shift[RW_BIT] &&
                    (r_shift[ADDR_MSB:ADDR_LSB] <= MAX_ADDR);

  // Strobes are registered on the SHIFT->CHECK transition so they are high
  // exactly for the single CHECK cycle.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_shift_next    = r_shift;
    w_wr_valid_next = 1'b0;
    w_err_next      = 1'b0;
    w_addr_next     = r_addr;
    w_data_next     = r_data;
    unique case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_state_next = SHIFT;
          w_cnt_next   = '0;
          w_shift_next = '0;
        end
      end
      SHIFT: begin
        if (w_ncs_rise) begin
          w_state_next = CHECK;
          if (w_accept) begin
            w_wr_valid_next = 1'b1;
            w_addr_next     = r_shift[ADDR_MSB:ADDR_LSB];
            w_data_next     = r_shift[DATA_MSB:0];
          end else begin
            w_err_next = 1'b1;
          end
        end else if (w_sclk_rise && !w_ncs_sync) begin
          if (r_cnt < CNT_W'(FRAME_BITS)) begin
            w_shift_next = {r_shift[FRAME_BITS-2:0], w_sdi};
            w_cnt_next   = r_cnt + 1'b1;
          end else if (r_cnt < CNT_W'(FRAME_BITS + 1)) begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      CHECK:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_wr_valid <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_shift    <= w_shift_next;
      r_wr_valid <= w_wr_valid_next;
      r_err      <= w_err_next;
      r_addr     <= w_addr_next;
      r_data     <= w_data_next;
    end
  end

  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_addr   = r_addr;
  assign bus.wr_data   = r_data;
  assign bus.frame_err = r_err;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: drives SPI frames at clk/8 and checks
// strobes, captured address/data, busy and strobe latency.
module tb_spi_frame_rx;

  logic clk = 1'b0;
  logic rst_n, sclk, ncs, sdi;

  int checks   = 0;
  int failures = 0;
  int n_wr     = 0;
  int n_err    = 0;
  int n_both   = 0;
  logic [6:0] cap_addr0 = '0, cap_addr1 = '0;
  logic [7:0] cap_data0 = '0, cap_data1 = '0;

  spi_frame_rx_if bus ();

  spi_frame_rx #(
    .SYNC_STAGES (2),
    .MAX_ADDR    (7'h04),
    .FRAME_BITS  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .ncs   (ncs),
    .sdi   (sdi),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_valid) begin
      n_wr++;
      cap_addr0 = cap_addr1;
      cap_data0 = cap_data1;
      cap_addr1 = bus.wr_addr;
      cap_data1 = bus.wr_data;
    end
    if (bus.frame_err) n_err++;
    if (bus.wr_valid && bus.frame_err) n_both++;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] val, input int unsigned nbits);
    ncs = 1'b0;
    tick(4);
    for (int i = int'(nbits) - 1; i >= 0; i--) begin
      sclk = 1'b0;
      sdi  = val[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
    sclk = 1'b0;
    tick(4);
    ncs = 1'b1;
  endtask

  // lat = number of clk edges after the ncs pin rise until a strobe is seen (0 = none)
  task automatic send_frame(input logic [31:0] val, input int unsigned nbits,
                            output int unsigned lat);
    send_bits(val, nbits);
    lat = 0;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick(1);
      if (lat == 0 && (bus.wr_valid || bus.frame_err)) lat = k;
    end
    tick(4);
  endtask

  initial begin
    int unsigned lat;
    int wr0, err0;

    rst_n = 1'b0; sclk = 1'b0; ncs = 1'b1; sdi = 1'b0;
    tick(3);
    check("rst_wr_valid",  {31'd0, bus.wr_valid},  32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_wr_addr",   {25'd0, bus.wr_addr},   32'd0);
    check("rst_wr_data",   {24'd0, bus.wr_data},   32'd0);
    rst_n = 1'b1;
    tick(4);

    // Legal write 0x8255
    wr0 = n_wr; err0 = n_err;
    send_frame(32'h8255, 16, lat);
    check("w8255_wr_cnt",  n_wr - wr0,  1);
    check("w8255_err_cnt", n_err - err0, 0);
    check("w8255_addr",    {25'd0, bus.wr_addr}, 32'h02);
    check("w8255_data",    {24'd0, bus.wr_data}, 32'h55);
    check("w8255_busy",    {31'd0, bus.busy},    32'd0);
    check("w8255_latency", lat, 4);

    // Read frame rejected, outputs hold
    wr0 = n_wr; err0 = n_err;
    send_frame(32'h0355, 16, lat);
    check("r0355_wr_cnt",  n_wr - wr0,  0);
    check("r0355_err_cnt", n_err - err0, 1);
    check("r0355_addr",    {25'd0, bus.wr_addr}, 32'h02);
    check("r0355_data",    {24'd0, bus.wr_data}, 32'h55);
    check("r0355_latency", lat, 4);

    // Address above MAX_ADDR
    wr0 = n_wr; err0 = n_err;
    send_frame(32'h85AA, 16, lat);
    check("w85AA_wr_cnt",  n_wr - wr0,  0);
    check("w85AA_err_cnt", n_err - err0, 1);
    check("w85AA_addr",    {25'd0, bus.wr_addr}, 32'h02);

    // Short frame, 12 bits
    wr0 = n_wr; err0 = n_err;
    send_frame(32'h00000825, 12, lat);
    check("short_wr_cnt",  n_wr - wr0,  0);
    check("short_err_cnt", n_err - err0, 1);

    // Long frame, 18 bits, first 16 = 0x84F0
    wr0 = n_wr; err0 = n_err;
    send_frame(32'h000213C3, 18, lat);
    check("long_wr_cnt",  n_wr - wr0,  0);
    check("long_err_cnt", n_err - err0, 1);
    check("long_data",    {24'd0, bus.wr_data}, 32'h55);

    // Reset after 9 bits of a frame
    wr0 = n_wr; err0 = n_err;
    ncs = 1'b0;
    tick(4);
    for (int i = 15; i >= 7; i--) begin
      sclk = 1'b0; sdi = 1'b1; tick(4);
      sclk = 1'b1; tick(4);
    end
    rst_n = 1'b0;
    tick(2);
    ncs = 1'b1; sclk = 1'b0; sdi = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("abort_wr_cnt",  n_wr - wr0,  0);
    check("abort_err_cnt", n_err - err0, 0);
    check("abort_busy",    {31'd0, bus.busy},    32'd0);
    check("abort_addr",    {25'd0, bus.wr_addr}, 32'h00);
    check("abort_data",    {24'd0, bus.wr_data}, 32'h00);

    // Full frame after the abort
    wr0 = n_wr; err0 = n_err;
    send_frame(32'h8401, 16, lat);
    check("w8401_wr_cnt",  n_wr - wr0,  1);
    check("w8401_err_cnt", n_err - err0, 0);
    check("w8401_addr",    {25'd0, bus.wr_addr}, 32'h04);
    check("w8401_data",    {24'd0, bus.wr_data}, 32'h01);
    check("w8401_latency", lat, 4);

    // Back-to-back frames, ncs high for 4 clk in between
    wr0 = n_wr; err0 = n_err;
    send_bits(32'h8011, 16);
    tick(4);
    send_bits(32'h8122, 16);
    tick(16);
    check("b2b_wr_cnt",  n_wr - wr0,  2);
    check("b2b_err_cnt", n_err - err0, 0);
    check("b2b_addr0",   {25'd0, cap_addr0}, 32'h00);
    check("b2b_data0",   {24'd0, cap_data0}, 32'h11);
    check("b2b_addr1",   {25'd0, cap_addr1}, 32'h01);
    check("b2b_data1",   {24'd0, cap_data1}, 32'h22);
    check("b2b_busy",    {31'd0, bus.busy},  32'd0);

    check("never_both_strobes", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
